// File: rtl/pic8259_pkg.sv
// Shared definitions for the 8259A bus front end: init-sequence states and
// the command-byte bit positions the write decoder inspects.
package pic8259_pkg;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } init_state_t;

  localparam int unsigned ICW1_D4   = 4;
  localparam int unsigned OCW_D3    = 3;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_IC4  = 0;

endpackage

// File: rtl/pic_bus_edge_detect.sv
// Registers one active-level bus qualifier and flags the cycle in which it
// is seen low after having been high.
module pic_bus_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic active,
  output logic fall
);

  logic active_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active;
    end
  end

  assign fall = active_q & ~active;

endmodule

// File: rtl/pic_bus_write_sequencer.sv
// 8259A write path: captures CPU writes, decodes each completed write into one
// ICW/OCW strobe and tracks the ICW1..ICW4 initialization sequence.
module pic_bus_write_sequencer
  import pic8259_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       read_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1_registers,
  output logic       write_operation_control_word_2_registers,
  output logic       write_operation_control_word_3_registers,
  output logic       read_strobe,
  output logic       initialization_in_progress
);

  logic        wr_act;
  logic        rd_act;
  logic        wr_fall;
  logic        rd_fall;
  logic [7:0]  data_q;
  logic        a0_q;
  logic        sngl;
  logic        ic4;
  init_state_t state;

  assign wr_act = ~chip_select_n & ~write_enable_n;
  // An overlapping WR# takes the cycle, so it is never seen as a read.
  assign rd_act = ~chip_select_n & ~read_enable_n & write_enable_n;

  pic_bus_edge_detect u_wr_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .active  (wr_act),
    .fall    (wr_fall)
  );

  pic_bus_edge_detect u_rd_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .active  (rd_act),
    .fall    (rd_fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      a0_q   <= 1'b0;
    end else if (wr_act) begin
      data_q <= data_bus_in;
      a0_q   <= address;
    end
  end

  assign internal_data_bus          = data_q;
  assign initialization_in_progress = (state != READY);

  // Strobes are decoded against the current state; the state itself advances
  // one edge later from the registered strobe, as the strobe drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                                    <= READY;
      sngl                                     <= 1'b1;
      ic4                                      <= 1'b0;
      write_initial_command_word_1             <= 1'b0;
      write_initial_command_word_2             <= 1'b0;
      write_initial_command_word_3             <= 1'b0;
      write_initial_command_word_4             <= 1'b0;
      write_operation_control_word_1_registers <= 1'b0;
      write_operation_control_word_2_registers <= 1'b0;
      write_operation_control_word_3_registers <= 1'b0;
      read_strobe                              <= 1'b0;
    end else begin
      write_initial_command_word_1             <= 1'b0;
      write_initial_command_word_2             <= 1'b0;
      write_initial_command_word_3             <= 1'b0;
      write_initial_command_word_4             <= 1'b0;
      write_operation_control_word_1_registers <= 1'b0;
      write_operation_control_word_2_registers <= 1'b0;
      write_operation_control_word_3_registers <= 1'b0;
      read_strobe                              <= rd_fall;

      if (write_initial_command_word_1) begin
        state <= WAIT_ICW2;
        sngl  <= data_q[ICW1_SNGL];
        ic4   <= data_q[ICW1_IC4];
      end else if (write_initial_command_word_2) begin
        if (!sngl) begin
          state <= WAIT_ICW3;
        end else if (ic4) begin
          state <= WAIT_ICW4;
        end else begin
          state <= READY;
        end
      end else if (write_initial_command_word_3) begin
        state <= ic4 ? WAIT_ICW4 : READY;
      end else if (write_initial_command_word_4) begin
        state <= READY;
      end

      if (wr_fall) begin
        if (!a0_q) begin
          if (data_q[ICW1_D4]) begin
            write_initial_command_word_1 <= 1'b1;
          end else if (state == READY) begin
            if (data_q[OCW_D3]) begin
              write_operation_control_word_3_registers <= 1'b1;
            end else begin
              write_operation_control_word_2_registers <= 1'b1;
            end
          end
        end else begin
          unique case (state)
            WAIT_ICW2: write_initial_command_word_2             <= 1'b1;
            WAIT_ICW3: write_initial_command_word_3             <= 1'b1;
            WAIT_ICW4: write_initial_command_word_4             <= 1'b1;
            READY:     write_operation_control_word_1_registers <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_bus_write_sequencer.sv
// Directed plus randomized bench for pic_bus_write_sequencer against a
// queue-based model of the initialization word sequence.
module tb_pic_bus_write_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       read_enable_n;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, read_strobe, in_prog;

  pic_bus_write_sequencer dut (
    .clock                                    (clock),
    .reset_n                                  (reset_n),
    .chip_select_n                            (chip_select_n),
    .write_enable_n                           (write_enable_n),
    .read_enable_n                            (read_enable_n),
    .address                                  (address),
    .data_bus_in                              (data_bus_in),
    .internal_data_bus                        (internal_data_bus),
    .write_initial_command_word_1             (icw1),
    .write_initial_command_word_2             (icw2),
    .write_initial_command_word_3             (icw3),
    .write_initial_command_word_4             (icw4),
    .write_operation_control_word_1_registers (ocw1),
    .write_operation_control_word_2_registers (ocw2),
    .write_operation_control_word_3_registers (ocw3),
    .read_strobe                              (read_strobe),
    .initialization_in_progress               (in_prog)
  );

  always #5 clock = ~clock;

  // Event codes: 0 none, 1..4 ICWn, 5 OCW1, 6 OCW2, 7 OCW3, 8 read.
  localparam int EV_NONE = 0, EV_OCW1 = 5, EV_OCW2 = 6, EV_OCW3 = 7, EV_READ = 8;

  typedef struct {
    logic [7:0] vec;
    logic [7:0] data;
    int         cyc;
  } obs_t;

  obs_t obs_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    logic [7:0] v;
    v = {read_strobe, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};
    if (v != 8'h00) obs_q.push_back('{vec: v, data: internal_data_bus, cyc: cyc});
  end

  // Model: list of ICWs still owed after ICW1, plus the last written byte.
  int         owed[$];
  logic [7:0] last_byte;

  function automatic int model_write(input logic a0, input logic [7:0] d);
    int code;
    last_byte = d;
    code = EV_NONE;
    if (!a0 && d[4]) begin
      owed.delete();
      owed.push_back(2);
      if (!d[1]) owed.push_back(3);
      if (d[0]) owed.push_back(4);
      code = 1;
    end else if (!a0) begin
      if (owed.size() == 0) code = d[3] ? EV_OCW3 : EV_OCW2;
    end else begin
      if (owed.size() != 0) code = owed.pop_front();
      else code = EV_OCW1;
    end
    return code;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_event(input string tag, input int code, input logic [7:0] d, input int rel);
    check({tag, "_count"}, obs_q.size(), (code != EV_NONE) ? 1 : 0);
    if (code != EV_NONE && obs_q.size() >= 1) begin
      check({tag, "_strobe"}, obs_q[0].vec, 8'h01 << (code - 1));
      check({tag, "_data"}, obs_q[0].data, d);
      check({tag, "_latency"}, obs_q[0].cyc, rel + 1);
    end
    check({tag, "_idb"}, internal_data_bus, last_byte);
    check({tag, "_inprog"}, in_prog, owed.size() != 0);
    obs_q.delete();
  endtask

  task automatic do_write(input string tag, input logic a0, input logic [7:0] d,
                          input int hold, input bit cs_early);
    int rel;
    int code;
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = a0;
    for (int i = 0; i < hold - 1; i++) begin
      data_bus_in = 8'($urandom);
      step();
    end
    data_bus_in = d;
    step();
    rel = cyc;
    chip_select_n = 1'b1;
    if (cs_early) begin
      data_bus_in = 8'($urandom);
      step();
    end
    write_enable_n = 1'b1;
    data_bus_in    = 8'($urandom);
    address        = 1'($urandom);
    code = model_write(a0, d);
    repeat (4) step();
    check_event(tag, code, d, rel);
  endtask

  task automatic do_read(input string tag);
    int rel;
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    data_bus_in   = 8'($urandom);
    step();
    step();
    rel = cyc;
    chip_select_n = 1'b1;
    read_enable_n = 1'b1;
    repeat (4) step();
    check_event(tag, EV_READ, last_byte, rel);
  endtask

  initial begin
    reset_n        = 1'b0;
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    read_enable_n  = 1'b1;
    address        = 1'b0;
    data_bus_in    = 8'h00;
    last_byte      = 8'h00;
    repeat (3) step();
    check("reset_idb", internal_data_bus, 8'h00);
    check("reset_inprog", in_prog, 1'b0);
    check("reset_strobes", {read_strobe, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}, 8'h00);
    reset_n = 1'b1;
    repeat (2) step();

    do_write("icw1_single", 1'b0, 8'h13, 2, 1'b0);
    check("inprog_after_icw1", in_prog, 1'b1);
    do_write("icw2_single", 1'b1, 8'h20, 1, 1'b0);
    do_write("icw4_single", 1'b1, 8'h01, 3, 1'b0);

    do_write("icw1_cascade", 1'b0, 8'h10, 2, 1'b0);
    do_write("icw2_cascade", 1'b1, 8'h08, 2, 1'b0);
    do_write("icw3_cascade", 1'b1, 8'h04, 2, 1'b0);
    do_write("ocw1", 1'b1, 8'hFF, 2, 1'b0);

    do_write("ocw3", 1'b0, 8'h0B, 2, 1'b0);
    do_write("ocw2", 1'b0, 8'h20, 2, 1'b0);

    do_write("icw1_restart_a", 1'b0, 8'h13, 2, 1'b0);
    do_write("ocw_ignored", 1'b0, 8'h0A, 2, 1'b0);
    do_write("icw1_restart_b", 1'b0, 8'h13, 2, 1'b0);
    do_write("icw2_restart", 1'b1, 8'h40, 2, 1'b0);
    do_write("icw4_restart", 1'b1, 8'h03, 2, 1'b0);

    do_write("cs_early", 1'b1, 8'h5A, 3, 1'b1);
    do_read("read_pulse");

    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 1'b0;
    data_bus_in    = 8'h13;
    step();
    step();
    reset_n = 1'b0;
    step();
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    step();
    reset_n = 1'b1;
    owed.delete();
    last_byte = 8'h00;
    repeat (4) step();
    check_event("reset_midwrite", EV_NONE, 8'h00, 0);
    check("reset_midwrite_strobes", {read_strobe, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}, 8'h00);

    for (int n = 0; n < 60; n++) begin
      logic       a0;
      logic [7:0] d;
      a0 = 1'($urandom);
      d  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a0   = 1'b0;
        d[4] = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) do_read("rand_read");
      else do_write("rand_write", a0, d, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic_bus_write_sequencer.md
# pic_bus_write_sequencer

Front-end write path of the 8259A model: samples the asynchronous CPU bus (CS#, WR#, RD#, A0, D[7:0]) in the `clock` domain and latches the written byte onto `internal_data_bus`. It decodes each completed write into exactly one single-cycle command-word strobe. It tracks the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence. It directly feeds the ICW/OCW register blocks, including the OCW3 block (`write_initial_command_word_1`, `write_operation_control_word_3_registers`, `internal_data_bus`).

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `chip_select_n`  in  1  CS#, active low
- `write_enable_n`  in  1  WR#, active low
- `read_enable_n`  in  1  RD#, active low
- `address`  in  1  A0
- `data_bus_in`  in  8  CPU data bus
- `internal_data_bus`  out  8  byte latched from the most recent write
- `write_initial_command_word_1` … `write_initial_command_word_4`  out  1 each  single-cycle ICW strobes
- `write_operation_control_word_1_registers`, `write_operation_control_word_2_registers`, `write_operation_control_word_3_registers`  out  1 each  single-cycle OCW strobes
- `read_strobe`  out  1  single cycle at the end of a chip-selected read
- `initialization_in_progress`  out  1  high from ICW1 until the last required ICW is written

## Operation
- Qualified write: `wr_act = !chip_select_n & !write_enable_n`.
  - Each cycle `wr_act` is high, `data_bus_in` and `address` are captured into the internal latches; `internal_data_bus` shows the captured byte.
- End of write: falling edge of the registered `wr_act` (high previous cycle, low this cycle).
  - This includes CS# rising before WR#.
  - It produces one decode event using the last captured byte/A0.
- Decode priority, exactly one strobe per event:
  - A0=0, D4=1 → ICW1; latch `sngl`=D1, `ic4`=D0; state→WAIT_ICW2. This applies from any state, including mid-sequence, which restarts the sequence.
  - A0=0, D4=0, D3=0 → OCW2. Ignored (no strobe) while `initialization_in_progress`.
  - A0=0, D4=0, D3=1 → OCW3. Ignored while `initialization_in_progress`.
  - A0=1 depends on state:
    - WAIT_ICW2 → ICW2; next state is WAIT_ICW3 if `sngl`=0, else WAIT_ICW4 if `ic4`=1, else READY.
    - WAIT_ICW3 → ICW3; next state is WAIT_ICW4 if `ic4`=1, else READY.
    - WAIT_ICW4 → ICW4; next state READY.
    - READY → OCW1.
- States (shared enum): READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4. `initialization_in_progress` = (state ≠ READY).
- Read: falling edge of the registered `!chip_select_n & !read_enable_n` → `read_strobe` for one cycle. Reads never change state or data.
- Simultaneous WR# and RD# active (illegal bus cycle): the write wins; `read_strobe` is suppressed for that overlap.

## Timing
- Reset values:
  - state=READY
  - `sngl`=1, `ic4`=0
  - all strobes 0, `read_strobe` 0
  - `internal_data_bus`=8'h00
  - `initialization_in_progress`=0
  - registered `wr_act`/`rd_act`=0
- Strobe latency:
  - Strobe is high in the cycle following the first clock edge that samples `wr_act` low after high.
  - Strobe lasts exactly 1 cycle.
  - `internal_data_bus` is stable, and equal to the written byte, during that cycle.
- The state update occurs on the same edge that drops the strobe, so the next write decodes against the new state.
- Back-to-back writes need ≥1 cycle of `wr_act` low between them. A 1-cycle gap yields two distinct strobes.
- Reset asserted mid-write: the event is discarded and no strobe fires after release. A write still active at reset release is captured but only decoded on its end edge.
- Bus inputs are assumed synchronous to `clock` (one sampling register); any external synchronizer belongs outside this block.

## Structure
- Package `pic8259_pkg`: state enum `init_state_t`, plus bit-position constants ICW1_D4, OCW_D3, ICW1_SNGL, ICW1_IC4.
- Sub-module `pic_bus_edge_detect`:
  - Registers one active-level signal and emits the falling-edge pulse.
  - Instantiated twice, for write and read.

## Test plan
- Reset, then ICW1=8'h13 (SNGL=1, IC4=1), ICW2=8'h20 with A0=1, ICW4=8'h01 with A0=1 → strobes ICW1, ICW2, ICW4 in order, no ICW3 strobe; `initialization_in_progress` drops after the ICW4 strobe.
- ICW1=8'h10 (cascade, no IC4), A0=1 writes 8'h08 then 8'h04 → ICW2 then ICW3 strobes; state READY; next A0=1 write of 8'hFF → OCW1 strobe with `internal_data_bus`=8'hFF.
- In READY: A0=0 8'h0B → OCW3 strobe only, `internal_data_bus`=8'h0B; A0=0 8'h20 → OCW2 strobe only.
- During WAIT_ICW2: A0=0 8'h0A → no strobe, state unchanged; then A0=0 8'h13 → ICW1 strobe, sequence restarts at WAIT_ICW2.
- CS# released one cycle before WR# → exactly one strobe, using the last byte captured while both were low; RD# pulse with CS# low → one `read_strobe`, no write strobe.
- Assert `reset_n` low during an active write, then release → no strobe, all outputs at reset values.
